tm1638_frame_sender: RTL and testbench

Serial write controller for the TM1638 LED/7-segment driver chip. It continuously refreshes the chip from the static per-digit segment registers (`hex[]`), a per-digit LED vector and a brightness setting. Each refresh frame is three STB-framed transactions: data-mode command, address plus 16 data bytes, then display control. It sits between the static HEX register bank and the board's STB/CLK/DIO pins. It is write-only; key scanning is out of scope.

---
 rtl/tm1638_pkg.sv | 16 +
 rtl/tm1638_byte_shifter.sv | 66 ++++++
 rtl/tm1638_frame_sender.sv | 144 ++++++++++++++
 tb/tb_tm1638_frame_sender.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tm1638_pkg.sv
// Shared constants and FSM state type for the TM1638 frame sender.
package tm1638_pkg;

    localparam logic [7:0] CMD_DATA_AUTO = 8'h40;
    localparam logic [7:0] CMD_ADDR0     = 8'hC0;
    localparam logic [7:0] CMD_DISP      = 8'h80;
    localparam int unsigned FRAME_BYTES  = 19;

    typedef enum logic [1:0] {
        StIdleGap,
        StStbSetup,
        StBits,
        StStbHold
    } state_e;

endpackage

// File: rtl/tm1638_byte_shifter.sv
// Free-running half-period timer plus LSB-first byte shifter driving the serial clock and data.
module tm1638_byte_shifter #(
    parameter int unsigned half = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tick,
    output logic       done,
    output logic       sclk,
    output logic       sdata
);

    localparam int unsigned cw = (half > 1) ? $clog2(half) : 1;

    logic [cw-1:0] cnt_q;
    logic          active_q;
    logic          phase_hi_q;
    logic [2:0]    bit_q;
    logic [6:0]    shreg_q;

    // Every FSM interval is a whole number of half-periods, so one timer paces everything.
    assign tick = (cnt_q == cw'(half - 1));
    assign done = tick && active_q && phase_hi_q && (bit_q == 3'd7);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            active_q   <= 1'b0;
            phase_hi_q <= 1'b0;
            bit_q      <= 3'd0;
            shreg_q    <= 7'd0;
            sclk       <= 1'b1;
            sdata      <= 1'b1;
        end else begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
            if (tick) begin
                // A start on the final high half chains the next byte with no gap.
                if (start) begin
                    active_q   <= 1'b1;
                    phase_hi_q <= 1'b0;
                    bit_q      <= 3'd0;
                    sclk       <= 1'b0;
                    sdata      <= data[0];
                    shreg_q    <= data[7:1];
                end else if (active_q && !phase_hi_q) begin
                    sclk       <= 1'b1;
                    phase_hi_q <= 1'b1;
                end else if (active_q) begin
                    if (bit_q != 3'd7) begin
                        bit_q      <= bit_q + 3'd1;
                        sclk       <= 1'b0;
                        phase_hi_q <= 1'b0;
                        sdata      <= shreg_q[0];
                        shreg_q    <= {1'b0, shreg_q[6:1]};
                    end else begin
                        active_q <= 1'b0;
                        sdata    <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/tm1638_frame_sender.sv
// Continuously refreshes a TM1638 from snapshotted segment, LED and brightness inputs.
module tm1638_frame_sender
    import tm1638_pkg::*;
#(
    parameter int unsigned clk_mhz  = 50,
    parameter int unsigned sclk_khz = 500,
    parameter int unsigned w_digit  = 8,
    parameter int unsigned w_seg    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [w_seg-1:0]   hex [w_digit],
    input  logic [w_digit-1:0] leds,
    input  logic [2:0]         brightness,
    input  logic               display_on,
    output logic               sio_stb,
    output logic               sio_clk,
    output logic               sio_data,
    output logic               busy,
    output logic               frame_done
);

    localparam int unsigned half = clk_mhz * 1000 / (2 * sclk_khz);
    localparam logic [4:0]  last_idx = 5'(FRAME_BYTES - 1);

    if (half < 1) begin : g_bad_half
        $error("tm1638_frame_sender: serial half-period is below one clock cycle");
    end
    if (sclk_khz > 1000 || w_digit < 1 || w_digit > 8) begin : g_bad_param
        $error("tm1638_frame_sender: sclk_khz or w_digit out of range");
    end

    state_e             state_q;
    logic [4:0]         idx_q;
    logic               gap_half_q;
    logic [w_seg-1:0]   sh_hex_q [w_digit];
    logic [w_digit-1:0] sh_leds_q;
    logic [2:0]         sh_bri_q;
    logic               sh_on_q;

    logic       tick;
    logic       done;
    logic       start;
    logic       ends_txn;
    logic [4:0] sel_idx;
    logic [4:0] grid_idx;
    logic [7:0] tx_byte;

    assign busy     = ~sio_stb;
    assign ends_txn = (idx_q == 5'd0) || (idx_q == 5'd17) || (idx_q == last_idx);
    assign start    = tick && ((state_q == StStbSetup) ||
                               ((state_q == StBits) && done && !ends_txn));

    // While shifting, the byte being loaded is the one after the current index.
    always_comb begin
        sel_idx  = (state_q == StBits) ? idx_q + 5'd1 : idx_q;
        grid_idx = (sel_idx - 5'd2) >> 1;
        tx_byte  = 8'h00;
        if (sel_idx == 5'd0) begin
            tx_byte = CMD_DATA_AUTO;
        end else if (sel_idx == 5'd1) begin
            tx_byte = CMD_ADDR0;
        end else if (sel_idx == last_idx) begin
            tx_byte = CMD_DISP | {4'b0000, sh_on_q, sh_bri_q};
        end else begin
            for (int g = 0; g < int'(w_digit); g++) begin
                if (32'(grid_idx) == g) begin
                    tx_byte = sel_idx[0] ? {7'b0, sh_leds_q[g]} : 8'(sh_hex_q[g]);
                end
            end
        end
    end

    tm1638_byte_shifter #(
        .half (half)
    ) u_shifter (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .data  (tx_byte),
        .tick  (tick),
        .done  (done),
        .sclk  (sio_clk),
        .sdata (sio_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdleGap;
            idx_q      <= 5'd0;
            gap_half_q <= 1'b0;
            sio_stb    <= 1'b1;
            frame_done <= 1'b0;
            for (int g = 0; g < int'(w_digit); g++) sh_hex_q[g] <= '0;
            sh_leds_q  <= '0;
            sh_bri_q   <= 3'd0;
            sh_on_q    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state_q)
                StIdleGap: begin
                    if (tick) begin
                        if (!gap_half_q) begin
                            gap_half_q <= 1'b1;
                        end else begin
                            gap_half_q <= 1'b0;
                            if (idx_q == 5'd0) begin
                                sh_hex_q  <= hex;
                                sh_leds_q <= leds;
                                sh_bri_q  <= brightness;
                                sh_on_q   <= display_on;
                            end
                            sio_stb <= 1'b0;
                            state_q <= StStbSetup;
                        end
                    end
                end
                StStbSetup: begin
                    if (tick) state_q <= StBits;
                end
                StBits: begin
                    if (done) begin
                        if (ends_txn) state_q <= StStbHold;
                        else          idx_q   <= idx_q + 5'd1;
                    end
                end
                StStbHold: begin
                    if (tick) begin
                        sio_stb <= 1'b1;
                        state_q <= StIdleGap;
                        if (idx_q == last_idx) begin
                            idx_q      <= 5'd0;
                            frame_done <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 5'd1;
                        end
                    end
                end
                default: state_q <= StIdleGap;
            endcase
        end
    end

endmodule

// File: tb/tb_tm1638_frame_sender.sv
// Bench for tm1638_frame_sender: decodes DIO into byte queues and checks them against a frame model.
module tb_tm1638_frame_sender;

    logic       clk;
    logic       rst;
    logic [7:0] hex [8];
    logic [7:0] leds;
    logic [2:0] brightness;
    logic       display_on;
    logic       sio_stb, sio_clk, sio_data, busy, frame_done;

    logic [7:0] hex4 [4];
    logic [3:0] leds4;
    logic       stb4, sclk4, data4, busy4, frame_done4;

    logic [7:0] exp_q [$];
    logic [7:0] rx_q [$];
    logic [7:0] rx4_q [$];
    int total = 0;
    int bad = 0;

    tm1638_frame_sender #(
        .clk_mhz  (1),
        .sclk_khz (100),
        .w_digit  (8),
        .w_seg    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hex        (hex),
        .leds       (leds),
        .brightness (brightness),
        .display_on (display_on),
        .sio_stb    (sio_stb),
        .sio_clk    (sio_clk),
        .sio_data   (sio_data),
        .busy       (busy),
        .frame_done (frame_done)
    );

    tm1638_frame_sender #(
        .clk_mhz  (1),
        .sclk_khz (100),
        .w_digit  (4),
        .w_seg    (8)
    ) dut4 (
        .clk        (clk),
        .rst        (rst),
        .hex        (hex4),
        .leds       (leds4),
        .brightness (brightness),
        .display_on (display_on),
        .sio_stb    (stb4),
        .sio_clk    (sclk4),
        .sio_data   (data4),
        .busy       (busy4),
        .frame_done (frame_done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DIO decoders: one byte per 8 rising serial clocks while STB is low.
    int nbit = 0, nbit4 = 0;
    logic [7:0] sh = 8'h00, sh4 = 8'h00;
    logic prev = 1'b1, prev4 = 1'b1;
    always @(negedge clk) begin
        if (sio_stb) begin
            nbit = 0;
        end else if (sio_clk && !prev) begin
            sh = {sio_data, sh[7:1]};
            nbit++;
            if (nbit == 8) begin
                rx_q.push_back(sh);
                nbit = 0;
            end
        end
        prev = sio_clk;
    end
    always @(negedge clk) begin
        if (stb4) begin
            nbit4 = 0;
        end else if (sclk4 && !prev4) begin
            sh4 = {data4, sh4[7:1]};
            nbit4++;
            if (nbit4 == 8) begin
                rx4_q.push_back(sh4);
                nbit4 = 0;
            end
        end
        prev4 = sclk4;
    end

    function automatic void push_frame(input logic [7:0] h [8], input logic [7:0] l,
                                       input logic [2:0] b, input logic on, input int nd);
        exp_q.push_back(8'h40);
        exp_q.push_back(8'hC0);
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(k < nd ? h[k] : 8'h00);
            exp_q.push_back(k < nd ? {7'b0, l[k]} : 8'h00);
        end
        exp_q.push_back({4'b1000, on, b});
    endfunction

    task automatic wait_done(input int budget, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        bit ok;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total += 5;
        if (sio_stb !== 1'b1) begin bad++; $display("FAIL reset_stb got=%b exp=1", sio_stb); end
        if (sio_clk !== 1'b1) begin bad++; $display("FAIL reset_clk got=%b exp=1", sio_clk); end
        if (sio_data !== 1'b1) begin bad++; $display("FAIL reset_data got=%b exp=1", sio_data); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (frame_done !== 1'b0) begin
            bad++; $display("FAIL reset_frame_done got=%b exp=0", frame_done);
        end
        rst = 1'b1;
        n = 0;
        while (sio_stb && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (n != 10) begin bad++; $display("FAIL first_stb_fall got=%0d exp=10", n); end
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL busy_when_stb_low got=%b exp=1", busy); end
        wait_done(2000, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL first_frame_done got=timeout exp=pulse"); end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 2000);
        total++;
        if (n != 1580) begin bad++; $display("FAIL frame_period got=%0d exp=1580", n); end
    endtask

    task automatic test_frame_bytes();
        bit ok;
        logic [7:0] e, g;
        wait_done(2000, ok);
        rx_q.delete();
        push_frame(hex, leds, brightness, display_on, 8);
        wait_done(2000, ok);
        total++;
        if (!ok || rx_q.size() != 19) begin
            bad++; $display("FAIL frame_bytes_count got=%0d exp=19", rx_q.size());
        end
        for (int i = 0; i < 19; i++) begin
            e = exp_q.pop_front();
            g = 8'hxx;
            if (rx_q.size() != 0) g = rx_q.pop_front();
            total++;
            if (g !== e) begin bad++; $display("FAIL frame_bytes[%0d] got=%h exp=%h", i, g, e); end
        end
    endtask

    task automatic test_brightness();
        bit ok;
        logic [7:0] e, g;
        for (int pass = 0; pass < 2; pass++) begin
            brightness = 3'd7;
            display_on = (pass == 0);
            wait_done(2000, ok);
            rx_q.delete();
            push_frame(hex, leds, brightness, display_on, 8);
            wait_done(2000, ok);
            total++;
            if (!ok || rx_q.size() != 19) begin
                bad++; $display("FAIL bright_count[%0d] got=%0d exp=19", pass, rx_q.size());
            end
            for (int i = 0; i < 19; i++) begin
                e = exp_q.pop_front();
                g = 8'hxx;
                if (rx_q.size() != 0) g = rx_q.pop_front();
                total++;
                if (g !== e) begin
                    bad++; $display("FAIL bright[%0d][%0d] got=%h exp=%h", pass, i, g, e);
                end
            end
        end
    endtask

    task automatic test_w_digit();
        int n;
        logic [7:0] h8 [8];
        logic [7:0] e, g;
        for (int k = 0; k < 8; k++) h8[k] = (k < 4) ? hex4[k] : 8'h00;
        for (int f = 0; f < 2; f++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!frame_done4 && n < 2000);
            if (f == 0) rx4_q.delete();
        end
        push_frame(h8, {4'b0000, leds4}, brightness, display_on, 4);
        total++;
        if (rx4_q.size() != 19) begin
            bad++; $display("FAIL wdigit_count got=%0d exp=19", rx4_q.size());
        end
        for (int i = 0; i < 19; i++) begin
            e = exp_q.pop_front();
            g = 8'hxx;
            if (rx4_q.size() != 0) g = rx4_q.pop_front();
            total++;
            if (g !== e) begin bad++; $display("FAIL wdigit[%0d] got=%h exp=%h", i, g, e); end
        end
    endtask

    task automatic test_mid_frame_change();
        bit ok;
        int n;
        logic [7:0] e, g;
        hex[2] = 8'h06;
        wait_done(2000, ok);
        rx_q.delete();
        push_frame(hex, leds, brightness, display_on, 8);
        n = 0;
        while (rx_q.size() < 5 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        hex[2] = 8'h5B;
        push_frame(hex, leds, brightness, display_on, 8);
        wait_done(2000, ok);
        wait_done(2000, ok);
        total++;
        if (!ok || rx_q.size() != 38) begin
            bad++; $display("FAIL midchange_count got=%0d exp=38", rx_q.size());
        end
        for (int i = 0; i < 38; i++) begin
            e = exp_q.pop_front();
            g = 8'hxx;
            if (rx_q.size() != 0) g = rx_q.pop_front();
            total++;
            if (g !== e) begin bad++; $display("FAIL midchange[%0d] got=%h exp=%h", i, g, e); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        logic [7:0] e, g;
        wait_done(2000, ok);
        rx_q.delete();
        n = 0;
        while (rx_q.size() < 9 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        total++;
        if (sio_stb !== 1'b0) begin bad++; $display("FAIL pre_reset_stb got=%b exp=0", sio_stb); end
        rst = 1'b0;
        #1;
        total += 4;
        if (sio_stb !== 1'b1) begin bad++; $display("FAIL async_rst_stb got=%b exp=1", sio_stb); end
        if (sio_clk !== 1'b1) begin bad++; $display("FAIL async_rst_clk got=%b exp=1", sio_clk); end
        if (sio_data !== 1'b1) begin
            bad++; $display("FAIL async_rst_data got=%b exp=1", sio_data);
        end
        if (busy !== 1'b0) begin bad++; $display("FAIL async_rst_busy got=%b exp=0", busy); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        rx_q.delete();
        rx4_q.delete();
        push_frame(hex, leds, brightness, display_on, 8);
        wait_done(2000, ok);
        total++;
        if (!ok || rx_q.size() != 19) begin
            bad++; $display("FAIL post_reset_count got=%0d exp=19", rx_q.size());
        end
        for (int i = 0; i < 19; i++) begin
            e = exp_q.pop_front();
            g = 8'hxx;
            if (rx_q.size() != 0) g = rx_q.pop_front();
            total++;
            if (g !== e) begin bad++; $display("FAIL post_reset[%0d] got=%h exp=%h", i, g, e); end
        end
    endtask

    initial begin
        rst = 1'b0;
        for (int k = 0; k < 8; k++) hex[k] = 8'h00;
        hex[0] = 8'h3F;
        leds = 8'b0000_0001;
        brightness = 3'd0;
        display_on = 1'b0;
        for (int k = 0; k < 4; k++) hex4[k] = 8'hFF;
        leds4 = 4'b0101;
        test_reset();
        test_frame_bytes();
        test_brightness();
        test_w_digit();
        test_mid_frame_change();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
